// File: rtl/decode_stage_hz_if.sv
// decode_stage_hz_if: bundles the decode-side inputs, writeback port, EX
// control (flush/hold), fetch back-pressure and the registered ID/EX outputs.
//   master : upstream/downstream environment (drives D, W, flush/hold inputs)
//   slave  : decode_stage_hz (drives stall_D and all *_E outputs)
interface decode_stage_hz_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DAT_WIDTH  = 32
);
    // Decode-stage inputs from the IF/ID register
    logic                  valid_D;
    logic [31:0]           Ins_D;
    logic [ADDR_WIDTH-1:0] PC_D;
    logic [ADDR_WIDTH-1:0] PC_4D;
    // Writeback port into the register file
    logic                  RegWrite_W;
    logic [4:0]            rd_W;
    logic [DAT_WIDTH-1:0]  Result_W;
    // Execute-stage control and fetch back-pressure
    logic                  flush_E;
    logic                  hold_E;
    logic                  stall_D;
    // ID/EX register outputs
    logic                  valid_E;
    logic                  RegWrite_E;
    logic                  ALUSrc_E;
    logic                  MemWrite_E;
    logic                  MemRead_E;
    logic                  Branch_E;
    logic                  MemtoReg_E;
    logic                  illegal_E;
    logic [3:0]            control_o_E;
    logic [DAT_WIDTH-1:0]  ImmExt_E;
    logic [DAT_WIDTH-1:0]  rdata1_E;
    logic [DAT_WIDTH-1:0]  rdata2_E;
    logic [4:0]            rs1_E;
    logic [4:0]            rs2_E;
    logic [4:0]            rd_E;
    logic [ADDR_WIDTH-1:0] PC_E;
    logic [ADDR_WIDTH-1:0] PC_4E;

    modport master (
        output valid_D, Ins_D, PC_D, PC_4D,
        output RegWrite_W, rd_W, Result_W,
        output flush_E, hold_E,
        input  stall_D,
        input  valid_E, RegWrite_E, ALUSrc_E, MemWrite_E, MemRead_E,
        input  Branch_E, MemtoReg_E, illegal_E, control_o_E,
        input  ImmExt_E, rdata1_E, rdata2_E, rs1_E, rs2_E, rd_E, PC_E, PC_4E
    );

    modport slave (
        input  valid_D, Ins_D, PC_D, PC_4D,
        input  RegWrite_W, rd_W, Result_W,
        input  flush_E, hold_E,
        output stall_D,
        output valid_E, RegWrite_E, ALUSrc_E, MemWrite_E, MemRead_E,
        output Branch_E, MemtoReg_E, illegal_E, control_o_E,
        output ImmExt_E, rdata1_E, rdata2_E, rs1_E, rs2_E, rd_E, PC_E, PC_4E
    );
endinterface

// File: rtl/decode_stage_hz.sv
// decode_stage_hz: RV32I decode stage with register file, load-use hazard
// detection, downstream hold, branch flush and an ID/EX pipeline register.
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : decode_stage_hz_if.slave (D inputs, W port, flush/hold,
//                combinational stall_D, registered *_E outputs)
// Optional feature: define DECODE_WB_BYPASS_EN to forward the writeback value
// straight into the read ports when W writes the register being read.
module decode_stage_hz #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DAT_WIDTH  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    decode_stage_hz_if.slave   bus
);

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned EXT_I    = DAT_WIDTH - 12;
    localparam int unsigned EXT_B    = DAT_WIDTH - 13;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Instruction fields
    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_rd;
    logic       w_ins30;

    assign w_opcode = bus.Ins_D[6:0];
    assign w_funct3 = bus.Ins_D[14:12];
    assign w_rs1    = bus.Ins_D[19:15];
    assign w_rs2    = bus.Ins_D[24:20];
    assign w_rd     = bus.Ins_D[11:7];
    assign w_ins30  = bus.Ins_D[30];

    // Main decoder outputs
    logic                 w_regwrite;
    logic                 w_alusrc;
    logic                 w_memwrite;
    logic                 w_memread;
    logic                 w_branch;
    logic                 w_memtoreg;
    logic                 w_illegal;
    logic                 w_uses_rs2;
    logic [1:0]           w_aluop;
    logic [3:0]           w_alu_ctl;
    logic [DAT_WIDTH-1:0] w_imm;

    // Register file and read data
    logic [DAT_WIDTH-1:0] r_rf [NUM_REGS];
    logic [DAT_WIDTH-1:0] w_rdata1;
    logic [DAT_WIDTH-1:0] w_rdata2;

    // Hazard / pipeline control
    logic w_load_use;
    logic w_bubble;
    logic w_load_data;

    // ID/EX register
    logic                  r_valid;
    logic                  r_regwrite;
    logic                  r_alusrc;
    logic                  r_memwrite;
    logic                  r_memread;
    logic                  r_branch;
    logic                  r_memtoreg;
    logic                  r_illegal;
    logic [3:0]            r_alu_ctl;
    logic [DAT_WIDTH-1:0]  r_imm;
    logic [DAT_WIDTH-1:0]  r_rdata1;
    logic [DAT_WIDTH-1:0]  r_rdata2;
    logic [4:0]            r_rs1;
    logic [4:0]            r_rs2;
    logic [4:0]            r_rd;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_pc4;

    // Opcode decode: control bits, immediate format and whether rs2 is read
    always_comb begin
        w_regwrite = 1'b0;
        w_alusrc   = 1'b0;
        w_memwrite = 1'b0;
        w_memread  = 1'b0;
        w_branch   = 1'b0;
        w_memtoreg = 1'b0;
        w_illegal  = 1'b0;
        w_uses_rs2 = 1'b0;
        w_aluop    = 2'b00;
        w_imm      = '0;
        case (w_opcode)
            OP_R: begin
                w_regwrite = 1'b1;
                w_aluop    = 2'b10;
                w_uses_rs2 = 1'b1;
            end
            OP_I: begin
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_aluop    = 2'b10;
                w_imm      = {{EXT_I{bus.Ins_D[31]}}, bus.Ins_D[31:20]};
            end
            OP_LOAD: begin
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_memread  = 1'b1;
                w_memtoreg = 1'b1;
                w_imm      = {{EXT_I{bus.Ins_D[31]}}, bus.Ins_D[31:20]};
            end
            OP_STORE: begin
                w_alusrc   = 1'b1;
                w_memwrite = 1'b1;
                w_uses_rs2 = 1'b1;
                w_imm      = {{EXT_I{bus.Ins_D[31]}}, bus.Ins_D[31:25], bus.Ins_D[11:7]};
            end
            OP_BRANCH: begin
                w_branch   = 1'b1;
                w_aluop    = 2'b01;
                w_uses_rs2 = 1'b1;
                w_imm      = {{EXT_B{bus.Ins_D[31]}}, bus.Ins_D[31], bus.Ins_D[7],
                              bus.Ins_D[30:25], bus.Ins_D[11:8], 1'b0};
            end
            default: begin
                w_illegal  = 1'b1;
            end
        endcase
    end

    // ALU operation select; Ins[30] picks SUB only for R-type, SRA for both
    always_comb begin
        w_alu_ctl = ALU_ADD;
        case (w_aluop)
            2'b01: w_alu_ctl = ALU_SUB;
            2'b10: begin
                case (w_funct3)
                    3'b000:  w_alu_ctl = (w_opcode == OP_R && w_ins30) ? ALU_SUB : ALU_ADD;
                    3'b001:  w_alu_ctl = ALU_SLL;
                    3'b010:  w_alu_ctl = ALU_SLT;
                    3'b011:  w_alu_ctl = ALU_SLTU;
                    3'b100:  w_alu_ctl = ALU_XOR;
                    3'b101:  w_alu_ctl = w_ins30 ? ALU_SRA : ALU_SRL;
                    3'b110:  w_alu_ctl = ALU_OR;
                    default: w_alu_ctl = ALU_AND;
                endcase
            end
            default: w_alu_ctl = ALU_ADD;
        endcase
    end

    // Register file write; x0 is never written so it always reads 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_rf[i] <= '0;
            end
        end else if (bus.RegWrite_W && bus.rd_W != 5'd0) begin
            r_rf[bus.rd_W] <= bus.Result_W;
        end
    end

    // Register file read ports
    always_comb begin
        w_rdata1 = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1];
        w_rdata2 = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2];
`ifdef DECODE_WB_BYPASS_EN
        if (bus.RegWrite_W && bus.rd_W != 5'd0 && bus.rd_W == w_rs1) begin
            w_rdata1 = bus.Result_W;
        end
        if (bus.RegWrite_W && bus.rd_W != 5'd0 && bus.rd_W == w_rs2) begin
            w_rdata2 = bus.Result_W;
        end
`endif
    end

    // Load in EX whose destination is read by the instruction in D
    assign w_load_use = bus.valid_D && r_valid && r_memread && (r_rd != 5'd0) &&
                        ((r_rd == w_rs1) || ((r_rd == w_rs2) && w_uses_rs2));

    // Priority flush > hold > load_use > advance
    assign w_bubble    = bus.flush_E || (!bus.hold_E && w_load_use);
    assign w_load_data = bus.flush_E || (!bus.hold_E && !w_load_use);
    assign bus.stall_D = rst_n && !bus.flush_E && (bus.hold_E || w_load_use);

    // ID/EX control bits: cleared on bubble, gated by valid_D on advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_branch   <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_bubble) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_branch   <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_load_data) begin
            r_valid    <= bus.valid_D;
            r_regwrite <= w_regwrite && bus.valid_D;
            r_memwrite <= w_memwrite && bus.valid_D;
            r_memread  <= w_memread  && bus.valid_D;
            r_branch   <= w_branch   && bus.valid_D;
            r_illegal  <= w_illegal  && bus.valid_D;
        end
    end

    // ID/EX data fields: load on flush or advance, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alusrc   <= 1'b0;
            r_memtoreg <= 1'b0;
            r_alu_ctl  <= '0;
            r_imm      <= '0;
            r_rdata1   <= '0;
            r_rdata2   <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_pc       <= '0;
            r_pc4      <= '0;
        end else if (w_load_data) begin
            r_alusrc   <= w_alusrc;
            r_memtoreg <= w_memtoreg;
            r_alu_ctl  <= w_alu_ctl;
            r_imm      <= w_imm;
            r_rdata1   <= w_rdata1;
            r_rdata2   <= w_rdata2;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_rd       <= w_rd;
            r_pc       <= bus.PC_D;
            r_pc4      <= bus.PC_4D;
        end
    end

    assign bus.valid_E     = r_valid;
    assign bus.RegWrite_E  = r_regwrite;
    assign bus.ALUSrc_E    = r_alusrc;
    assign bus.MemWrite_E  = r_memwrite;
    assign bus.MemRead_E   = r_memread;
    assign bus.Branch_E    = r_branch;
    assign bus.MemtoReg_E  = r_memtoreg;
    assign bus.illegal_E   = r_illegal;
    assign bus.control_o_E = r_alu_ctl;
    assign bus.ImmExt_E    = r_imm;
    assign bus.rdata1_E    = r_rdata1;
    assign bus.rdata2_E    = r_rdata2;
    assign bus.rs1_E       = r_rs1;
    assign bus.rs2_E       = r_rs2;
    assign bus.rd_E        = r_rd;
    assign bus.PC_E        = r_pc;
    assign bus.PC_4E       = r_pc4;

endmodule
